// File: rtl/dragonfang_pkg.sv
// Shared vector-unit types: division control word, sequencer states and SEW helpers.
package dragonfang_pkg;

  localparam int DEFAULT_VLEN    = 512;
  localparam int DATAPATH_WIDTH  = 64;
  localparam int VRF_CHUNK_COUNT = DEFAULT_VLEN / DATAPATH_WIDTH;

  typedef enum logic [1:0] {
    SEW_8,
    SEW_16,
    SEW_32,
    SEW_64
  } sew_t;

  typedef enum logic [1:0] {
    DIV_OP_DIVU,
    DIV_OP_DIV,
    DIV_OP_REMU,
    DIV_OP_REM
  } division_op_t;

  typedef struct packed {
    division_op_t op;
    sew_t         sew;
  } execution_vector_t;

  typedef enum logic [2:0] {
    DIV_SEQ_IDLE,
    DIV_SEQ_READ,
    DIV_SEQ_EXECUTE,
    DIV_SEQ_WRITE,
    DIV_SEQ_DONE
  } division_sequencer_state_t;

  function automatic logic [3:0] get_sew_bytes(input execution_vector_t execution_vector);
    case (execution_vector.sew)
      SEW_8:   return 4'd1;
      SEW_16:  return 4'd2;
      SEW_32:  return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/vector_tail_mask_generator.sv
// Per-byte write enable for one 64-bit chunk: a byte is live iff its absolute
// byte offset within the register lies below total_bytes.
module vector_tail_mask_generator #(
  parameter int TOTAL_BYTES_WIDTH = 7,
  parameter int CHUNK_INDEX_WIDTH = 3
) (
  input  logic [TOTAL_BYTES_WIDTH-1:0] total_bytes,
  input  logic [CHUNK_INDEX_WIDTH-1:0] chunk,
  output logic [7:0]                   byte_mask
);

  localparam int COMPARE_WIDTH = (CHUNK_INDEX_WIDTH + 4 > TOTAL_BYTES_WIDTH) ?
                                 CHUNK_INDEX_WIDTH + 4 : TOTAL_BYTES_WIDTH;

  logic [COMPARE_WIDTH-1:0] chunk_base;

  always_comb begin
    byte_mask  = '0;
    chunk_base = COMPARE_WIDTH'({chunk, 3'b000});
    for (int b = 0; b < 8; b++) begin
      byte_mask[b] = (chunk_base + COMPARE_WIDTH'(b)) < COMPARE_WIDTH'(total_bytes);
    end
  end

endmodule

// File: rtl/vector_division_sequencer.sv
// Issue/writeback sequencer around the combinational vector_division_unit:
// walks vs2/vs1 in 64-bit chunks (read, execute, write) and pulses done at the end.
module vector_division_sequencer
  import dragonfang_pkg::*;
#(
  parameter int VLEN                   = DEFAULT_VLEN,
  parameter int CHUNK_WIDTH            = DATAPATH_WIDTH,
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  localparam int VL_WIDTH              = $clog2(VLEN / 8) + 1,
  localparam int CHUNK_INDEX_WIDTH     = $clog2(VLEN / CHUNK_WIDTH)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              issue_valid,
  output logic                              issue_ready,
  input  execution_vector_t                 issue_execution_vector,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] issue_vs2_address,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] issue_vs1_address,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] issue_vd_address,
  input  logic [VL_WIDTH-1:0]               issue_vl,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] vrf_vs2_address,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] vrf_vs1_address,
  output logic [CHUNK_INDEX_WIDTH-1:0]      vrf_read_chunk,
  input  logic [CHUNK_WIDTH-1:0]            vrf_vs2_data,
  input  logic [CHUNK_WIDTH-1:0]            vrf_vs1_data,
  output execution_vector_t                 div_execution_vector,
  output logic [CHUNK_WIDTH-1:0]            div_vs2,
  output logic [CHUNK_WIDTH-1:0]            div_vs1,
  input  logic [CHUNK_WIDTH-1:0]            div_vd,
  output logic                              vrf_write_enable,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] vrf_write_address,
  output logic [CHUNK_INDEX_WIDTH-1:0]      vrf_write_chunk,
  output logic [CHUNK_WIDTH-1:0]            vrf_write_data,
  output logic [7:0]                        vrf_write_byte_mask,
  output logic                              done
);

  localparam int TOTAL_BYTES_WIDTH = VL_WIDTH;
  localparam int CHUNK_COUNT_WIDTH = CHUNK_INDEX_WIDTH + 1;

  division_sequencer_state_t state, next_state;

  execution_vector_t                 execution_vector_q;
  logic [REGISTER_ADDRESS_WIDTH-1:0] vs2_address_q, vs1_address_q, vd_address_q;
  logic [TOTAL_BYTES_WIDTH-1:0]      total_bytes_q;
  logic [CHUNK_COUNT_WIDTH-1:0]      chunk_count_q;
  logic [CHUNK_INDEX_WIDTH-1:0]      chunk_q;
  logic [CHUNK_WIDTH-1:0]            result_q;

  logic [TOTAL_BYTES_WIDTH-1:0]      sew_bytes;
  logic [VL_WIDTH-1:0]               max_elements;
  logic [VL_WIDTH-1:0]               effective_vl;
  logic [TOTAL_BYTES_WIDTH-1:0]      issue_total_bytes;
  logic [TOTAL_BYTES_WIDTH:0]        rounded_bytes;
  logic [CHUNK_COUNT_WIDTH-1:0]      issue_chunk_count;
  logic                              last_chunk;
  logic [7:0]                        tail_mask;

  // Clamp vl to one register's worth of elements, then size the walk in chunks.
  always_comb begin
    sew_bytes = TOTAL_BYTES_WIDTH'(get_sew_bytes(issue_execution_vector));
    case (issue_execution_vector.sew)
      SEW_8:   max_elements = VL_WIDTH'(VLEN / 8);
      SEW_16:  max_elements = VL_WIDTH'(VLEN / 16);
      SEW_32:  max_elements = VL_WIDTH'(VLEN / 32);
      default: max_elements = VL_WIDTH'(VLEN / 64);
    endcase
    effective_vl      = (issue_vl < max_elements) ? issue_vl : max_elements;
    issue_total_bytes = effective_vl * sew_bytes;
    rounded_bytes     = {1'b0, issue_total_bytes} + (TOTAL_BYTES_WIDTH + 1)'(7);
    issue_chunk_count = CHUNK_COUNT_WIDTH'(rounded_bytes >> 3);
  end

  assign last_chunk = (CHUNK_COUNT_WIDTH'(chunk_q) + CHUNK_COUNT_WIDTH'(1)) == chunk_count_q;

  vector_tail_mask_generator #(
    .TOTAL_BYTES_WIDTH(TOTAL_BYTES_WIDTH),
    .CHUNK_INDEX_WIDTH(CHUNK_INDEX_WIDTH)
  ) u_tail_mask (
    .total_bytes(total_bytes_q),
    .chunk      (chunk_q),
    .byte_mask  (tail_mask)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= DIV_SEQ_IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      execution_vector_q <= '0;
      vs2_address_q      <= '0;
      vs1_address_q      <= '0;
      vd_address_q       <= '0;
      total_bytes_q      <= '0;
      chunk_count_q      <= '0;
      chunk_q            <= '0;
      result_q           <= '0;
    end else begin
      case (state)
        DIV_SEQ_IDLE: begin
          if (issue_valid) begin
            execution_vector_q <= issue_execution_vector;
            vs2_address_q      <= issue_vs2_address;
            vs1_address_q      <= issue_vs1_address;
            vd_address_q       <= issue_vd_address;
            total_bytes_q      <= issue_total_bytes;
            chunk_count_q      <= issue_chunk_count;
            chunk_q            <= '0;
          end
        end
        DIV_SEQ_EXECUTE: result_q <= div_vd;
        DIV_SEQ_WRITE: begin
          if (!last_chunk) chunk_q <= chunk_q + CHUNK_INDEX_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held so an abort never leaks a write.
  always_comb begin
    next_state           = state;
    issue_ready          = 1'b0;
    vrf_vs2_address      = '0;
    vrf_vs1_address      = '0;
    vrf_read_chunk       = '0;
    div_execution_vector = '0;
    div_vs2              = '0;
    div_vs1              = '0;
    vrf_write_enable     = 1'b0;
    vrf_write_address    = '0;
    vrf_write_chunk      = '0;
    vrf_write_data       = '0;
    vrf_write_byte_mask  = '0;
    done                 = 1'b0;
    if (!reset) begin
      case (state)
        DIV_SEQ_IDLE: begin
          issue_ready = 1'b1;
          if (issue_valid) begin
            next_state = (issue_chunk_count == '0) ? DIV_SEQ_DONE : DIV_SEQ_READ;
          end
        end
        DIV_SEQ_READ: begin
          vrf_vs2_address = vs2_address_q;
          vrf_vs1_address = vs1_address_q;
          vrf_read_chunk  = chunk_q;
          next_state      = DIV_SEQ_EXECUTE;
        end
        DIV_SEQ_EXECUTE: begin
          div_execution_vector = execution_vector_q;
          div_vs2              = vrf_vs2_data;
          div_vs1              = vrf_vs1_data;
          next_state           = DIV_SEQ_WRITE;
        end
        DIV_SEQ_WRITE: begin
          vrf_write_enable    = 1'b1;
          vrf_write_address   = vd_address_q;
          vrf_write_chunk     = chunk_q;
          vrf_write_data      = result_q;
          vrf_write_byte_mask = tail_mask;
          next_state          = last_chunk ? DIV_SEQ_DONE : DIV_SEQ_READ;
        end
        DIV_SEQ_DONE: begin
          done       = 1'b1;
          next_state = DIV_SEQ_IDLE;
        end
        default: next_state = DIV_SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_division_sequencer.sv
// Directed bench for vector_division_sequencer with a VRF model and a
// reference division unit; expected results are hand-computed constants.
module tb_vector_division_sequencer;
  import dragonfang_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              issue_valid;
  logic              issue_ready;
  execution_vector_t issue_execution_vector;
  logic [4:0]        issue_vs2_address, issue_vs1_address, issue_vd_address;
  logic [6:0]        issue_vl;
  logic [4:0]        vrf_vs2_address, vrf_vs1_address;
  logic [2:0]        vrf_read_chunk;
  logic [63:0]       vrf_vs2_data, vrf_vs1_data;
  execution_vector_t div_execution_vector;
  logic [63:0]       div_vs2, div_vs1, div_vd;
  logic              vrf_write_enable;
  logic [4:0]        vrf_write_address;
  logic [2:0]        vrf_write_chunk;
  logic [63:0]       vrf_write_data;
  logic [7:0]        vrf_write_byte_mask;
  logic              done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  vector_division_sequencer dut (
    .clock                 (clock),
    .reset                 (reset),
    .issue_valid           (issue_valid),
    .issue_ready           (issue_ready),
    .issue_execution_vector(issue_execution_vector),
    .issue_vs2_address     (issue_vs2_address),
    .issue_vs1_address     (issue_vs1_address),
    .issue_vd_address      (issue_vd_address),
    .issue_vl              (issue_vl),
    .vrf_vs2_address       (vrf_vs2_address),
    .vrf_vs1_address       (vrf_vs1_address),
    .vrf_read_chunk        (vrf_read_chunk),
    .vrf_vs2_data          (vrf_vs2_data),
    .vrf_vs1_data          (vrf_vs1_data),
    .div_execution_vector  (div_execution_vector),
    .div_vs2               (div_vs2),
    .div_vs1               (div_vs1),
    .div_vd                (div_vd),
    .vrf_write_enable      (vrf_write_enable),
    .vrf_write_address     (vrf_write_address),
    .vrf_write_chunk       (vrf_write_chunk),
    .vrf_write_data        (vrf_write_data),
    .vrf_write_byte_mask   (vrf_write_byte_mask),
    .done                  (done)
  );

  // Reference division unit: RISC-V divide-by-zero and signed-overflow results.
  function automatic logic [63:0] div_model(input execution_vector_t ev,
                                            input logic [63:0] a_all,
                                            input logic [63:0] b_all);
    int bytes;
    int bits;
    logic [63:0] m;
    logic [63:0] res;
    bytes = int'(get_sew_bytes(ev));
    bits  = bytes * 8;
    m     = (bits == 64) ? '1 : ((64'd1 << bits) - 64'd1);
    res   = '0;
    for (int l = 0; l < 8 / bytes; l++) begin
      logic [63:0] ua, ub, r, smin;
      longint sa, sbv;
      ua   = (a_all >> (l * bits)) & m;
      ub   = (b_all >> (l * bits)) & m;
      smin = ~(m >> 1);
      sa   = ua[bits-1] ? longint'(ua | ~m) : longint'(ua);
      sbv  = ub[bits-1] ? longint'(ub | ~m) : longint'(ub);
      case (ev.op)
        DIV_OP_DIVU: r = (ub == 0) ? '1 : ua / ub;
        DIV_OP_REMU: r = (ub == 0) ? ua : ua % ub;
        DIV_OP_DIV: begin
          if (sbv == 0) r = '1;
          else if (sa == longint'(smin) && sbv == -1) r = ua;
          else r = 64'(sa / sbv);
        end
        default: begin
          if (sbv == 0) r = ua;
          else if (sa == longint'(smin) && sbv == -1) r = '0;
          else r = 64'(sa % sbv);
        end
      endcase
      res = res | ((r & m) << (l * bits));
    end
    return res;
  endfunction

  always_comb div_vd = div_model(div_execution_vector, div_vs2, div_vs1);

  // VRF model: registered reads, byte-masked writes, write/done logging.
  logic [63:0] vrf [32][8];
  logic        preload_en = 1'b0;
  logic [4:0]  preload_addr = '0;
  logic [2:0]  preload_chunk = '0;
  logic [63:0] preload_data = '0;
  int          write_count = 0;
  int          done_count = 0;
  logic [63:0] log_data  [64];
  logic [7:0]  log_mask  [64];
  logic [2:0]  log_chunk [64];
  logic [4:0]  log_addr  [64];

  always @(posedge clock) begin
    vrf_vs2_data <= vrf[vrf_vs2_address][vrf_read_chunk];
    vrf_vs1_data <= vrf[vrf_vs1_address][vrf_read_chunk];
    if (preload_en) vrf[preload_addr][preload_chunk] <= preload_data;
    if (vrf_write_enable) begin
      for (int b = 0; b < 8; b++) begin
        if (vrf_write_byte_mask[b])
          vrf[vrf_write_address][vrf_write_chunk][b*8 +: 8] <= vrf_write_data[b*8 +: 8];
      end
      log_data[write_count % 64]  <= vrf_write_data;
      log_mask[write_count % 64]  <= vrf_write_byte_mask;
      log_chunk[write_count % 64] <= vrf_write_chunk;
      log_addr[write_count % 64]  <= vrf_write_address;
      write_count <= write_count + 1;
    end
    if (done) done_count <= done_count + 1;
  end

  function automatic execution_vector_t make_ev(input division_op_t op, input sew_t sew);
    execution_vector_t e;
    e.op  = op;
    e.sew = sew;
    return e;
  endfunction

  task automatic preload(input logic [4:0] r, input logic [2:0] c, input logic [63:0] d);
    @(negedge clock);
    preload_en    = 1'b1;
    preload_addr  = r;
    preload_chunk = c;
    preload_data  = d;
    @(negedge clock);
    preload_en = 1'b0;
  endtask

  task automatic drive_issue(input execution_vector_t ev, input logic [4:0] vs2a,
                             input logic [4:0] vs1a, input logic [4:0] vda, input logic [6:0] vl);
    issue_execution_vector = ev;
    issue_vs2_address      = vs2a;
    issue_vs1_address      = vs1a;
    issue_vd_address       = vda;
    issue_vl               = vl;
    issue_valid            = 1'b1;
  endtask

  task automatic run_instr(input execution_vector_t ev, input logic [4:0] vs2a,
                           input logic [4:0] vs1a, input logic [4:0] vda,
                           input logic [6:0] vl, output int latency);
    drive_issue(ev, vs2a, vs1a, vda, vl);
    @(posedge clock);
    #1 issue_valid = 1'b0;
    latency = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clock);
      if (done) begin
        latency = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    vectors++;
    if (issue_ready !== 1'b0 || vrf_write_enable !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: ready/we/done got %b%b%b expected 000",
               issue_ready, vrf_write_enable, done);
    end
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (issue_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: got %b expected 1", issue_ready);
    end
    vectors++;
    if (div_vs2 !== '0 || div_vs1 !== '0 || div_execution_vector !== '0 ||
        vrf_write_data !== '0 || vrf_write_byte_mask !== '0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: div_vs2=%h div_ev=%h wdata=%h mask=%h done=%b expected all 0",
               div_vs2, div_execution_vector, vrf_write_data, vrf_write_byte_mask, done);
    end
  endtask

  task automatic test_vdivu_32();
    int lat;
    int base;
    int idx;
    for (int c = 0; c < 8; c++) begin
      preload(5'd2, 3'(c), 64'h00000064_00000064);
      preload(5'd3, 3'(c), 64'h00000007_00000007);
      preload(5'd4, 3'(c), 64'hAAAA_AAAA_AAAA_AAAA);
    end
    base = write_count;
    run_instr(make_ev(DIV_OP_DIVU, SEW_32), 5'd2, 5'd3, 5'd4, 7'd16, lat);
    vectors++;
    if (lat !== 25) begin
      miscompares++;
      $display("[TB] FAIL vdivu32_latency: got %0d expected 25", lat);
    end
    vectors++;
    if (write_count - base !== 8) begin
      miscompares++;
      $display("[TB] FAIL vdivu32_writes: got %0d expected 8", write_count - base);
    end
    for (int i = 0; i < 8; i++) begin
      idx = (base + i) % 64;
      vectors++;
      if (log_data[idx] !== 64'h0000000E_0000000E || log_mask[idx] !== 8'hFF ||
          log_chunk[idx] !== 3'(i) || log_addr[idx] !== 5'd4) begin
        miscompares++;
        $display("[TB] FAIL vdivu32_write%0d: got data=%h mask=%h chunk=%0d addr=%0d expected 0000000e0000000e ff %0d 4",
                 i, log_data[idx], log_mask[idx], log_chunk[idx], log_addr[idx], i);
      end
    end
  endtask

  task automatic test_vdiv_8();
    preload(5'd11, 3'd0, 64'hF6F6_F6F6_F6F6_F6F6);
    preload(5'd12, 3'd0, 64'h0303_0303_0303_0303);
    preload(5'd13, 3'd0, 64'h1111_1111_1111_1111);
    drive_issue(make_ev(DIV_OP_DIV, SEW_8), 5'd11, 5'd12, 5'd13, 7'd5);
    @(posedge clock);
    #1 issue_valid = 1'b0;
    @(negedge clock);
    vectors++;
    if (vrf_vs2_address !== 5'd11 || vrf_vs1_address !== 5'd12 || vrf_read_chunk !== 3'd0 ||
        div_vs2 !== '0 || issue_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL vdiv8_read: got vs2a=%0d vs1a=%0d chunk=%0d div_vs2=%h ready=%b expected 11 12 0 0 0",
               vrf_vs2_address, vrf_vs1_address, vrf_read_chunk, div_vs2, issue_ready);
    end
    @(negedge clock);
    vectors++;
    if (div_vs2 !== 64'hF6F6_F6F6_F6F6_F6F6 || div_vs1 !== 64'h0303_0303_0303_0303 ||
        div_execution_vector !== make_ev(DIV_OP_DIV, SEW_8) || vrf_write_enable !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL vdiv8_execute: got vs2=%h vs1=%h ev=%h we=%b expected f6.. 03.. %h 0",
               div_vs2, div_vs1, div_execution_vector, vrf_write_enable, make_ev(DIV_OP_DIV, SEW_8));
    end
    @(negedge clock);
    vectors++;
    if (vrf_write_enable !== 1'b1 || vrf_write_data !== 64'hFDFD_FDFD_FDFD_FDFD ||
        vrf_write_byte_mask !== 8'h1F || vrf_write_chunk !== 3'd0 || vrf_write_address !== 5'd13) begin
      miscompares++;
      $display("[TB] FAIL vdiv8_write: got we=%b data=%h mask=%h chunk=%0d addr=%0d expected 1 fdfdfdfdfdfdfdfd 1f 0 13",
               vrf_write_enable, vrf_write_data, vrf_write_byte_mask, vrf_write_chunk, vrf_write_address);
    end
    @(negedge clock);
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL vdiv8_done: got %b expected 1 at cycle 4", done);
    end
    @(negedge clock);
    vectors++;
    if (done !== 1'b0 || issue_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL vdiv8_after: got done=%b ready=%b expected 0 1", done, issue_ready);
    end
    vectors++;
    if (vrf[13][0] !== 64'h1111_11FD_FDFD_FDFD) begin
      miscompares++;
      $display("[TB] FAIL vdiv8_tail: got %h expected 111111fdfdfdfdfd", vrf[13][0]);
    end
  endtask

  task automatic test_vl_zero();
    int lat;
    int base;
    base = write_count;
    run_instr(make_ev(DIV_OP_REM, SEW_16), 5'd2, 5'd3, 5'd4, 7'd0, lat);
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("[TB] FAIL vl0_latency: got %0d expected 1", lat);
    end
    @(negedge clock);
    vectors++;
    if (issue_ready !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL vl0_ready: got ready=%b done=%b expected 1 0", issue_ready, done);
    end
    vectors++;
    if (write_count - base !== 0) begin
      miscompares++;
      $display("[TB] FAIL vl0_writes: got %0d expected 0", write_count - base);
    end
  endtask

  task automatic test_vremu_64();
    logic [63:0] exp_rem [8];
    int lat;
    int base;
    int idx;
    exp_rem = '{64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd0, 64'd1, 64'd2};
    for (int c = 0; c < 8; c++) begin
      preload(5'd5, 3'(c), 64'd100 + 64'(c));
      preload(5'd6, 3'(c), 64'd7);
    end
    base = write_count;
    run_instr(make_ev(DIV_OP_REMU, SEW_64), 5'd5, 5'd6, 5'd7, 7'd100, lat);
    vectors++;
    if (lat !== 25) begin
      miscompares++;
      $display("[TB] FAIL vremu64_latency: got %0d expected 25", lat);
    end
    vectors++;
    if (write_count - base !== 8) begin
      miscompares++;
      $display("[TB] FAIL vremu64_writes: got %0d expected 8", write_count - base);
    end
    for (int i = 0; i < 8; i++) begin
      idx = (base + i) % 64;
      vectors++;
      if (log_data[idx] !== exp_rem[i] || log_mask[idx] !== 8'hFF || log_chunk[idx] !== 3'(i)) begin
        miscompares++;
        $display("[TB] FAIL vremu64_write%0d: got data=%h mask=%h chunk=%0d expected %h ff %0d",
                 i, log_data[idx], log_mask[idx], log_chunk[idx], exp_rem[i], i);
      end
    end
  endtask

  task automatic test_tail_mask();
    int lat;
    int base;
    for (int c = 0; c < 2; c++) begin
      preload(5'd24, 3'(c), 64'h0032_0032_0032_0032);
      preload(5'd25, 3'(c), 64'h0005_0005_0005_0005);
      preload(5'd26, 3'(c), 64'hCCCC_CCCC_CCCC_CCCC);
    end
    base = write_count;
    run_instr(make_ev(DIV_OP_DIVU, SEW_16), 5'd24, 5'd25, 5'd26, 7'd7, lat);
    vectors++;
    if (lat !== 7 || write_count - base !== 2) begin
      miscompares++;
      $display("[TB] FAIL tail_latency: got lat=%0d writes=%0d expected 7 2", lat, write_count - base);
    end
    vectors++;
    if (log_mask[base % 64] !== 8'hFF || log_mask[(base + 1) % 64] !== 8'h3F) begin
      miscompares++;
      $display("[TB] FAIL tail_masks: got %h %h expected ff 3f",
               log_mask[base % 64], log_mask[(base + 1) % 64]);
    end
    vectors++;
    if (vrf[26][0] !== 64'h000A_000A_000A_000A || vrf[26][1] !== 64'hCCCC_000A_000A_000A) begin
      miscompares++;
      $display("[TB] FAIL tail_vrf: got %h %h expected 000a000a000a000a cccc000a000a000a",
               vrf[26][0], vrf[26][1]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int base;
    int base_done;
    for (int c = 0; c < 8; c++) preload(5'd9, 3'(c), 64'h5555_5555_5555_5555);
    preload(5'd14, 3'd0, 64'hFFFF_FFFF_FFFF_FFEC);
    preload(5'd15, 3'd0, 64'd6);
    preload(5'd16, 3'd0, 64'd0);
    base      = write_count;
    base_done = done_count;
    drive_issue(make_ev(DIV_OP_DIVU, SEW_32), 5'd2, 5'd3, 5'd9, 7'd16);
    @(posedge clock);
    #1 issue_valid = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    vectors++;
    if (issue_ready !== 1'b0 || vrf_write_enable !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_hold: got ready=%b we=%b expected 0 0", issue_ready, vrf_write_enable);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    vectors++;
    if (issue_ready !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_ready: got ready=%b done=%b expected 1 0", issue_ready, done);
    end
    repeat (4) @(negedge clock);
    vectors++;
    if (write_count - base !== 1 || done_count - base_done !== 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_abort: got writes=%0d dones=%0d expected 1 0",
               write_count - base, done_count - base_done);
    end
    vectors++;
    if (vrf[9][0] !== 64'h0000000E_0000000E || vrf[9][1] !== 64'h5555_5555_5555_5555) begin
      miscompares++;
      $display("[TB] FAIL midreset_vrf: got %h %h expected 0000000e0000000e 5555555555555555",
               vrf[9][0], vrf[9][1]);
    end
    run_instr(make_ev(DIV_OP_DIV, SEW_64), 5'd14, 5'd15, 5'd16, 7'd1, lat);
    vectors++;
    if (lat !== 4 || vrf[16][0] !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      miscompares++;
      $display("[TB] FAIL postreset_vdiv64: got lat=%0d vd=%h expected 4 fffffffffffffffd", lat, vrf[16][0]);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int base_done;
    int idx;
    logic exp_ready;
    logic exp_done;
    preload(5'd20, 3'd0, 64'hFFFFFF9C_00000064);
    preload(5'd21, 3'd0, 64'h00000007_00000007);
    base      = write_count;
    base_done = done_count;
    drive_issue(make_ev(DIV_OP_DIV, SEW_32), 5'd20, 5'd21, 5'd22, 7'd2);
    for (int i = 0; i < 20; i++) begin
      exp_ready = (i % 5 == 0);
      exp_done  = (i % 5 == 4);
      vectors++;
      if (issue_ready !== exp_ready || done !== exp_done) begin
        miscompares++;
        $display("[TB] FAIL b2b_cycle%0d: got ready=%b done=%b expected %b %b",
                 i, issue_ready, done, exp_ready, exp_done);
      end
      @(negedge clock);
    end
    issue_valid = 1'b0;
    @(negedge clock);
    vectors++;
    if (write_count - base !== 4 || done_count - base_done !== 4) begin
      miscompares++;
      $display("[TB] FAIL b2b_counts: got writes=%0d dones=%0d expected 4 4",
               write_count - base, done_count - base_done);
    end
    for (int i = 0; i < 4; i++) begin
      idx = (base + i) % 64;
      vectors++;
      if (log_data[idx] !== 64'hFFFFFFF2_0000000E || log_chunk[idx] !== 3'd0 || log_mask[idx] !== 8'hFF) begin
        miscompares++;
        $display("[TB] FAIL b2b_write%0d: got data=%h chunk=%0d mask=%h expected fffffff20000000e 0 ff",
                 i, log_data[idx], log_chunk[idx], log_mask[idx]);
      end
    end
  endtask

  initial begin
    reset                  = 1'b1;
    issue_valid            = 1'b0;
    issue_execution_vector = '0;
    issue_vs2_address      = '0;
    issue_vs1_address      = '0;
    issue_vd_address       = '0;
    issue_vl               = '0;
    test_reset();
    test_vdivu_32();
    test_vdiv_8();
    test_vl_zero();
    test_vremu_64();
    test_tail_mask();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
